// File: rtl/adxl362_pkg.sv
// Shared definitions for the ADXL362 FIFO packer: channel tags, FSM encoding, set size.
// Optional feature macro: ADXL362_FIFO_TEMP_EN (appends the temperature word to each set).
package adxl362_pkg;

  // 2-bit channel tags placed in word bits [15:14]
  localparam logic [1:0] CH_X = 2'b00;
  localparam logic [1:0] CH_Y = 2'b01;
  localparam logic [1:0] CH_Z = 2'b10;
  localparam logic [1:0] CH_T = 2'b11;

`ifdef ADXL362_FIFO_TEMP_EN
  localparam int unsigned SET_BYTES = 8;
`else
  localparam int unsigned SET_BYTES = 6;
`endif

  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StPulse
  } state_t;

  // Byte lane of a 16-bit word; the FIFO layout is LSB byte first
  function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/adxl362_fifo_packer_if.sv
// Sample-side and FIFO-side signal bundle of the ADXL362 FIFO packer.
// slave: the packer; master: whatever drives samples and consumes FIFO strobes.
interface adxl362_fifo_packer_if #(
  parameter int unsigned CNT_W = 10
);
  logic             fifo_en;
  logic             sample_valid;
  logic [11:0]      x_data;
  logic [11:0]      y_data;
  logic [11:0]      z_data;
  logic [11:0]      temp_data;
  logic [8:0]       wm_samples;
  logic             flush_req;
  logic             fifo_rd;
  logic [7:0]       data_wr;
  logic             write;
  logic             flush;
  logic [CNT_W-1:0] occupancy;
  logic             watermark;
  logic             overrun;
  logic             busy;

  modport slave (
    input  fifo_en, sample_valid, x_data, y_data, z_data, temp_data, wm_samples,
    input  flush_req, fifo_rd,
    output data_wr, write, flush, occupancy, watermark, overrun, busy
  );

  modport master (
    output fifo_en, sample_valid, x_data, y_data, z_data, temp_data, wm_samples,
    output flush_req, fifo_rd,
    input  data_wr, write, flush, occupancy, watermark, overrun, busy
  );
endinterface

// File: rtl/adxl362_word_fmt.sv
// Formats one 12-bit sample into a tagged 16-bit FIFO word: {id, sign x2, sample}.
module adxl362_word_fmt (
  input  logic [1:0]  id,
  input  logic [11:0] sample,
  output logic [15:0] word
);

  // Pure combinational tagging with sign extension of bit 11
  always_comb begin
    word = {id, {2{sample[11]}}, sample};
  end

endmodule

// File: rtl/adxl362_fifo_packer.sv
// ADXL362 FIFO packer: captures a sample set, serialises it into byte writes with a
// SETUP/PULSE strobe pair per byte, and tracks occupancy, watermark and overrun.
// Optional feature macro: ADXL362_FIFO_TEMP_EN (adds the temperature word after Z).
module adxl362_fifo_packer
  import adxl362_pkg::*;
#(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned CNT_W = 10
) (
  input logic                  clk,
  input logic                  rst_n,
  adxl362_fifo_packer_if.slave bus
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [11:0]      x_q, y_q, z_q;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             ovr_q, ovr_d;
  logic [7:0]       data_wr_q, data_wr_d;
  logic             write_q, write_d;
  logic             flush_q;

  logic             room;
  logic             accept;
  logic             last;
  logic             inc, dec;
  logic [11:0]      x_cur, y_cur, z_cur;
  logic [15:0]      x_word, y_word, z_word, sel_word;
  logic [9:0]       wm_bytes;

`ifdef ADXL362_FIFO_TEMP_EN
  logic [11:0]      t_q, t_cur;
  logic [15:0]      t_word;
`else
  logic             unused_temp;
  assign unused_temp = ^bus.temp_data;
`endif

  // Usable capacity is DEPTH-1 bytes; pointer-equal means empty in the FIFO itself
  assign room   = (32'(occ_q) + SET_BYTES) <= (DEPTH - 1);
  assign accept = (state_q == StIdle) && bus.sample_valid && bus.fifo_en && room &&
                  !bus.flush_req;
  assign last   = (idx_q == IDX_W'(SET_BYTES - 1));
  assign inc    = (state_q == StPulse);
  assign dec    = bus.fifo_rd && (occ_q != '0);

  // The first byte is formatted from the live inputs, since the latch lands on the same edge
  assign x_cur = accept ? bus.x_data : x_q;
  assign y_cur = accept ? bus.y_data : y_q;
  assign z_cur = accept ? bus.z_data : z_q;

  adxl362_word_fmt u_fmt_x (.id(CH_X), .sample(x_cur), .word(x_word));
  adxl362_word_fmt u_fmt_y (.id(CH_Y), .sample(y_cur), .word(y_word));
  adxl362_word_fmt u_fmt_z (.id(CH_Z), .sample(z_cur), .word(z_word));

`ifdef ADXL362_FIFO_TEMP_EN
  assign t_cur = accept ? bus.temp_data : t_q;
  adxl362_word_fmt u_fmt_t (.id(CH_T), .sample(t_cur), .word(t_word));
`endif

  // Word selection for the byte about to be presented
  always_comb begin
    sel_word = 16'h0000;
    case (idx_d[2:1])
      2'd0:    sel_word = x_word;
      2'd1:    sel_word = y_word;
      2'd2:    sel_word = z_word;
`ifdef ADXL362_FIFO_TEMP_EN
      default: sel_word = t_word;
`else
      default: sel_word = 16'h0000;
`endif
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // FSM next state; flush aborts any set in progress
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (bus.flush_req) begin
      state_d = StIdle;
      idx_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_d = StSetup;
            idx_d   = '0;
          end
        end
        StSetup: state_d = StPulse;
        StPulse: begin
          if (last) begin
            state_d = StIdle;
          end else begin
            state_d = StSetup;
            idx_d   = idx_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs: data_wr only moves on entry to SETUP so it is stable around write
  always_comb begin
    data_wr_d = data_wr_q;
    write_d   = (state_d == StPulse);
    if (state_d == StSetup) begin
      data_wr_d = pick_byte(sel_word, idx_d[0]);
    end
  end

  // Occupancy and sticky overrun next state
  always_comb begin
    occ_d = occ_q + CNT_W'(inc) - CNT_W'(dec);
    ovr_d = ovr_q;
    if (bus.sample_valid && bus.fifo_en && ((state_q != StIdle) || !room)) begin
      ovr_d = 1'b1;
    end
    if (bus.flush_req) begin
      occ_d = '0;
      ovr_d = 1'b0;
    end
  end

  // Sample latch, counters and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
`ifdef ADXL362_FIFO_TEMP_EN
      t_q       <= '0;
`endif
      occ_q     <= '0;
      ovr_q     <= 1'b0;
      data_wr_q <= '0;
      write_q   <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      if (accept) begin
        x_q <= bus.x_data;
        y_q <= bus.y_data;
        z_q <= bus.z_data;
`ifdef ADXL362_FIFO_TEMP_EN
        t_q <= bus.temp_data;
`endif
      end
      occ_q     <= occ_d;
      ovr_q     <= ovr_d;
      data_wr_q <= data_wr_d;
      write_q   <= write_d;
      flush_q   <= bus.flush_req;
    end
  end

  assign wm_bytes      = {bus.wm_samples, 1'b0};
  assign bus.data_wr   = data_wr_q;
  assign bus.write     = write_q;
  assign bus.flush     = flush_q;
  assign bus.occupancy = occ_q;
  assign bus.overrun   = ovr_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.watermark = (bus.wm_samples != '0) && (32'(occ_q) >= 32'(wm_bytes));

endmodule

// File: tb/tb_adxl362_fifo_packer.sv
// Self-checking bench for adxl362_fifo_packer: vector table of sample sets, a byte
// scoreboard fed on stimulus and drained on each rising edge of write.
module tb_adxl362_fifo_packer;
  import adxl362_pkg::*;

  localparam int unsigned SB = adxl362_pkg::SET_BYTES;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] z;
    logic [11:0] t;
    logic [63:0] exp;  // expected bytes, first byte in [7:0]
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  adxl362_fifo_packer_if #(.CNT_W(10)) bus ();

  adxl362_fifo_packer #(.DEPTH(512), .CNT_W(10)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;
  int unsigned nwrites = 0;
  int unsigned model_occ = 0;
  logic        model_ovr = 1'b0;
  logic        prev_wr = 1'b0;
  logic [7:0]  sb[$];
  vec_t        vecs[6];

  function automatic logic [15:0] fmt(input logic [1:0] id, input logic [11:0] s);
    return {id, s[11], s[11], s};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; outputs sampled on the falling edge, FIFO-side byte capture on write rising
  task automatic tick();
    logic [7:0] e;
    @(posedge clk);
    @(negedge clk);
    if (bus.write && !prev_wr) begin
      nwrites++;
      if (sb.size() == 0) begin
        chk("unexpected_write", 32'(bus.data_wr), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("data_wr", 32'(bus.data_wr), 32'(e));
      end
    end
    prev_wr = bus.write;
  endtask

  task automatic check_status(input string tag);
    logic exp_wm;
    exp_wm = (bus.wm_samples != 0) && (model_occ >= 2 * 32'(bus.wm_samples));
    chk({tag, "_occ"}, 32'(bus.occupancy), model_occ);
    chk({tag, "_wm"}, 32'(bus.watermark), 32'(exp_wm));
    chk({tag, "_ovr"}, 32'(bus.overrun), 32'(model_ovr));
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic set_inputs(input vec_t v);
    bus.x_data    = v.x;
    bus.y_data    = v.y;
    bus.z_data    = v.z;
    bus.temp_data = v.t;
  endtask

  // Send one set; rd_at / extra_at (busy-cycle index, -1 = none) inject fifo_rd / sample_valid
  task automatic run_set(input vec_t v, input int rd_at, input int extra_at);
    int cnt;
    int unsigned base;
    base = model_occ;
    set_inputs(v);
    for (int k = 0; k < int'(SB); k++) sb.push_back(v.exp[8*k+:8]);
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    cnt = 0;
    while (bus.busy && cnt < 40) begin
      bus.fifo_rd      = (cnt == rd_at);
      bus.sample_valid = (cnt == extra_at);
      tick();
      cnt++;
      if (rd_at > 0 && cnt == rd_at + 1) begin
        chk("rd_on_pulse_occ", 32'(bus.occupancy), base + 32'((rd_at - 1) / 2));
      end
    end
    bus.fifo_rd      = 1'b0;
    bus.sample_valid = 1'b0;
    model_occ = base + SB - ((rd_at >= 0) ? 1 : 0);
    if (extra_at >= 0) model_ovr = 1'b1;
    chk("busy_cycles", 32'(cnt), 2 * SB);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    check_status("set");
  endtask

  task automatic pop_byte();
    bus.fifo_rd = 1'b1;
    tick();
    bus.fifo_rd = 1'b0;
    if (model_occ > 0) model_occ--;
  endtask

  initial begin
    int n0;
    int guard;

    vecs[0] = '{x: 12'h123, y: 12'hFFF, z: 12'h800, t: 12'h07F, exp: 64'hC07F_B800_7FFF_0123};
    vecs[1] = '{x: 12'h7FF, y: 12'h001, z: 12'hFFE, t: 12'h800, exp: 64'hF800_BFFE_4001_07FF};
    vecs[2] = '{x: 12'h000, y: 12'h000, z: 12'h000, t: 12'h000, exp: 64'hC000_8000_4000_0000};
    for (int i = 3; i < 6; i++) begin
      vecs[i].x = 12'($urandom_range(0, 4095));
      vecs[i].y = 12'($urandom_range(0, 4095));
      vecs[i].z = 12'($urandom_range(0, 4095));
      vecs[i].t = 12'($urandom_range(0, 4095));
      vecs[i].exp = {fmt(CH_T, vecs[i].t), fmt(CH_Z, vecs[i].z), fmt(CH_Y, vecs[i].y),
                     fmt(CH_X, vecs[i].x)};
    end

    bus.fifo_en = 1'b1;
    bus.sample_valid = 1'b0;
    bus.flush_req = 1'b0;
    bus.fifo_rd = 1'b0;
    bus.wm_samples = 9'd3;
    set_inputs(vecs[0]);

    // Reset
    #2 rst_n = 1'b0;
    #1;
    chk("rst_data_wr", 32'(bus.data_wr), 0);
    chk("rst_write", 32'(bus.write), 0);
    chk("rst_flush", 32'(bus.flush), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_status("reset");

    // Spec vector also exercises the watermark (3 words = 6 bytes)
    run_set(vecs[0], -1, -1);
    pop_byte();
    check_status("wm_pop");

    // Table-driven sets
    for (int i = 0; i < 6; i++) run_set(vecs[i], -1, -1);

    // fifo_rd coincident with a PULSE
    run_set(vecs[1], 1, -1);

    // fifo_en low: set discarded silently
    bus.fifo_en = 1'b0;
    n0 = nwrites;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    repeat (3) tick();
    bus.fifo_en = 1'b1;
    chk("en_off_writes", 32'(nwrites - n0), 0);
    check_status("en_off");

    // Fill to capacity, trim to 508, then overflow
    guard = 0;
    while (model_occ + SB <= 511 && guard < 200) begin
      run_set(vecs[2], -1, -1);
      guard++;
    end
    while (model_occ > 508) pop_byte();
    check_status("fill508");
    n0 = nwrites;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    repeat (4) tick();
    model_ovr = 1'b1;
    chk("full_writes", 32'(nwrites - n0), 0);
    check_status("full");

    // Plain flush clears occupancy and overrun
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    model_occ = 0;
    model_ovr = 1'b0;
    chk("flush_pulse", 32'(bus.flush), 1);
    check_status("flush");
    tick();
    chk("flush_one_cycle", 32'(bus.flush), 0);

    // Flush after byte 3 of a set; sample_valid in the flush cycle is ignored
    set_inputs(vecs[1]);
    for (int k = 0; k < int'(SB); k++) sb.push_back(vecs[1].exp[8*k+:8]);
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    n0 = nwrites;
    guard = 0;
    while (nwrites - n0 < 3 && guard < 40) begin
      tick();
      guard++;
    end
    chk("mid_writes_seen", 32'(nwrites - n0), 3);
    bus.flush_req = 1'b1;
    bus.sample_valid = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    bus.sample_valid = 1'b0;
    sb.delete();
    chk("mid_flush_pulse", 32'(bus.flush), 1);
    chk("mid_flush_write", 32'(bus.write), 0);
    check_status("mid_flush");
    tick();
    chk("mid_flush_one_cycle", 32'(bus.flush), 0);
    chk("mid_flush_idle", 32'(bus.busy), 0);

    // fifo_rd at zero occupancy is ignored
    pop_byte();
    check_status("rd_empty");

    // Next set restarts at byte 0
    run_set(vecs[0], -1, -1);

    // sample_valid while busy drops the set and flags overrun
    run_set(vecs[3], -1, 4);

    // Asynchronous reset mid-set
    set_inputs(vecs[4]);
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_data_wr", 32'(bus.data_wr), 0);
    chk("arst_write", 32'(bus.write), 0);
    chk("arst_flush", 32'(bus.flush), 0);
    chk("arst_occ", 32'(bus.occupancy), 0);
    chk("arst_ovr", 32'(bus.overrun), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    prev_wr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
